// File: rtl/demux_striping_n.sv
// Round-robin word striper: each valid input word lands on the lane named by lane_ptr.
// Optional feature: define DEMUX_STRIPING_CNT_EN to add a 16-bit saturating word_count output.
module demux_striping_n #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int PTR_W  = 3
) (
    input  logic                    clk_2f,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       data_input,
    input  logic                    valid_in,
    input  logic [PTR_W-1:0]        active_lanes,
    input  logic                    hold_on_idle,
    output logic [LANES*DATA_W-1:0] lane_data,
    output logic [LANES-1:0]        valid_out,
    output logic [PTR_W-1:0]        lane_ptr,
    output logic                    round_done
`ifdef DEMUX_STRIPING_CNT_EN
    ,
    output logic [15:0]             word_count
`endif
);

    logic [LANES*DATA_W-1:0] lane_data_r;
    logic [LANES-1:0]        valid_r;
    logic [PTR_W-1:0]        ptr_r;
    logic                    done_r;

    logic [PTR_W-1:0]        n_s;
    logic [PTR_W-1:0]        last_s;
    logic                    wr_en_s;
    logic                    adv_s;
    logic [PTR_W-1:0]        ptr_nxt_s;
    logic                    done_nxt_s;
    logic [LANES*DATA_W-1:0] lane_data_nxt_s;
    logic [LANES-1:0]        valid_nxt_s;

    // Effective lane count and pointer/round bookkeeping for the coming edge.
    always_comb begin
        n_s        = active_lanes;
        last_s     = {PTR_W{1'b0}};
        wr_en_s    = 1'b0;
        adv_s      = 1'b0;
        ptr_nxt_s  = ptr_r;
        done_nxt_s = 1'b0;
        if ((active_lanes == {PTR_W{1'b0}}) || (active_lanes > PTR_W'(LANES))) begin
            n_s = PTR_W'(LANES);
        end else begin
            n_s = active_lanes;
        end
        last_s  = n_s - PTR_W'(1);
        // A pointer left beyond a shrunken lane count writes nothing this edge.
        wr_en_s = (ptr_r < n_s);
        adv_s   = valid_in | ~hold_on_idle;
        if (adv_s) begin
            if (ptr_r >= last_s) begin
                ptr_nxt_s = {PTR_W{1'b0}};
            end else begin
                ptr_nxt_s = ptr_r + PTR_W'(1);
            end
        end else begin
            ptr_nxt_s = ptr_r;
        end
        if (valid_in && wr_en_s && (ptr_r == last_s)) begin
            done_nxt_s = 1'b1;
        end else begin
            done_nxt_s = 1'b0;
        end
    end

    // Per-lane next state: write the targeted lane, retire lanes beyond N, hold the rest.
    always_comb begin
        lane_data_nxt_s = lane_data_r;
        valid_nxt_s     = valid_r;
        for (int j = 0; j < LANES; j++) begin
            if (PTR_W'(j) >= n_s) begin
                valid_nxt_s[j] = 1'b0;
            end else if (wr_en_s && (ptr_r == PTR_W'(j))) begin
                valid_nxt_s[j] = valid_in;
                if (valid_in) begin
                    lane_data_nxt_s[j*DATA_W +: DATA_W] = data_input;
                end else begin
                    lane_data_nxt_s[j*DATA_W +: DATA_W] = lane_data_r[j*DATA_W +: DATA_W];
                end
            end else begin
                valid_nxt_s[j] = valid_r[j];
            end
        end
    end

    // State registers; reset drops everything at once so a partial round is discarded.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            lane_data_r <= {(LANES*DATA_W){1'b0}};
            valid_r     <= {LANES{1'b0}};
            ptr_r       <= {PTR_W{1'b0}};
            done_r      <= 1'b0;
        end else begin
            lane_data_r <= lane_data_nxt_s;
            valid_r     <= valid_nxt_s;
            ptr_r       <= ptr_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

`ifdef DEMUX_STRIPING_CNT_EN
    logic [15:0] cnt_r;

    // Saturating count of accepted words.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            cnt_r <= 16'h0000;
        end else if (valid_in && (cnt_r != 16'hFFFF)) begin
            cnt_r <= cnt_r + 16'h0001;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign word_count = cnt_r;
`endif

    assign lane_data  = lane_data_r;
    assign valid_out  = valid_r;
    assign lane_ptr   = ptr_r;
    assign round_done = done_r;

endmodule
